// File: rtl/noc_output_port_allocator.sv
// Output-port switch allocator for a 5-port wormhole NOC router.
// Rotating round-robin between packets, grant held for a whole packet,
// downstream buffer credits tracked locally with a sticky overflow flag.
module noc_output_port_allocator #(
  parameter int PORT_ID   = 2,
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    req_valid_i,
  input  logic [14:0]   nexthop_addr_i,
  input  logic [4:0]    flit_tail_i,
  input  logic          credit_return_i,
  output logic [4:0]    grant_o,
  output logic [2:0]    xbar_sel_o,
  output logic          xbar_valid_o,
  output logic [CW-1:0] credit_count_o,
  output logic          busy_o,
  output logic          credit_err_o
);

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    LOCKED   = 1'b1;
  localparam logic [2:0]    SELF     = 3'(PORT_ID);
  localparam logic [4:0]    NOT_SELF = ~(5'b00001 << PORT_ID);
  localparam logic [2:0]    PTR_RST  = (PORT_ID == 0) ? 3'd1 : 3'd0;
  localparam logic [CW-1:0] FULL     = CW'(BUF_DEPTH);

  // Next index after idx in the 4 -> 0 ring, never landing on this port.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    logic [2:0] n;
    n = (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
    if (n == SELF) begin
      n = (n >= 3'd4) ? 3'd0 : n + 3'd1;
    end
    return n;
  endfunction

  logic [0:0]    state_reg, state_next;
  logic [2:0]    ptr_reg, ptr_next;
  logic [2:0]    owner_reg, owner_next;
  logic [CW-1:0] credit_reg, credit_next;
  logic          err_reg, err_next;

  logic [4:0]    match;
  logic          found;
  logic [2:0]    win_idx;
  logic          grant_valid;
  logic [2:0]    grant_idx;
  logic          grant_tail;

  // Head-flit eligibility: valid request whose next hop is this port.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_elig
      assign match[gi] = req_valid_i[gi] & NOT_SELF[gi] &
                         (nexthop_addr_i[3*gi +: 3] == SELF);
    end
  endgenerate

  // Round-robin search starting at ptr, wrapping modulo 5.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    found   = 1'b0;
    win_idx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, ptr_reg} + 4'(k);
      if (sum >= 4'd5) begin
        sum = sum - 4'd5;
      end
      idx = sum[2:0];
      if (!found && match[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Grant decision: owner while locked, arbiter winner while idle, never without credit.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    if (credit_reg != '0 && reset) begin
      if (state_reg == LOCKED) begin
        grant_valid = req_valid_i[owner_reg];
        grant_idx   = owner_reg;
      end else begin
        grant_valid = found;
        grant_idx   = win_idx;
      end
    end
    grant_tail = grant_valid & flit_tail_i[grant_idx];
  end

  // Output drive: one-hot grant and matching crossbar select.
  always_comb begin
    grant_o        = grant_valid ? (5'b00001 << grant_idx) : 5'b00000;
    xbar_sel_o     = grant_valid ? grant_idx : 3'd0;
    xbar_valid_o   = grant_valid;
    credit_count_o = credit_reg;
    busy_o         = (state_reg == LOCKED);
    credit_err_o   = err_reg;
  end

  // Packet lock and priority pointer updates on each granted flit.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    if (grant_valid) begin
      if (grant_tail) begin
        state_next = IDLE;
        ptr_next   = next_idx(grant_idx);
      end else begin
        state_next = LOCKED;
        owner_next = grant_idx;
      end
    end
  end

  // Credit accounting: grant consumes, return refunds, both cancel out.
  always_comb begin
    credit_next = credit_reg;
    err_next    = err_reg;
    case ({grant_valid, credit_return_i})
      2'b10: credit_next = credit_reg - CW'(1);
      2'b01: begin
        if (credit_reg == FULL) begin
          err_next = 1'b1;
        end else begin
          credit_next = credit_reg + CW'(1);
        end
      end
      default: credit_next = credit_reg;
    endcase
  end

  // State registers; reset drops any lock and refills credits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= PTR_RST;
      owner_reg  <= 3'd0;
      credit_reg <= FULL;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      owner_reg  <= owner_next;
      credit_reg <= credit_next;
      err_reg    <= err_next;
    end
  end

endmodule

// File: tb/tb_noc_output_port_allocator.sv
// Testbench for noc_output_port_allocator (PORT_ID=2, BUF_DEPTH=4).
// Directed scenarios followed by random traffic, checked against a
// packet-level reference model.
module tb_noc_output_port_allocator;

  localparam int PID = 2;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic [4:0]    req_valid;
  logic [14:0]   nexthop_addr;
  logic [4:0]    flit_tail;
  logic          credit_return;
  logic [4:0]    grant;
  logic [2:0]    xbar_sel;
  logic          xbar_valid;
  logic [CW-1:0] credit_count;
  logic          busy;
  logic          credit_err;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_locked, m_owner, m_ptr, m_cred, m_err;

  noc_output_port_allocator #(.PORT_ID(PID), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_i(req_valid),
    .nexthop_addr_i(nexthop_addr),
    .flit_tail_i(flit_tail),
    .credit_return_i(credit_return),
    .grant_o(grant),
    .xbar_sel_o(xbar_sel),
    .xbar_valid_o(xbar_valid),
    .credit_count_o(credit_count),
    .busy_o(busy),
    .credit_err_o(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH; m_err = 0;
  endfunction

  // Which input the packet-level rules say crosses now (-1 = none).
  function automatic int model_pick();
    if (m_cred == 0) return -1;
    if (m_locked != 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < 5; k++) begin
      int i;
      i = (m_ptr + k) % 5;
      if (i != PID && req_valid[i] && nexthop_addr[3*i +: 3] == 3'(PID)) return i;
    end
    return -1;
  endfunction

  function automatic void model_clock(input int g);
    if (g >= 0) begin
      if (flit_tail[g]) begin
        int n;
        m_locked = 0;
        n = (g + 1) % 5;
        if (n == PID) n = (n + 1) % 5;
        m_ptr = n;
      end else begin
        m_locked = 1;
        m_owner = g;
      end
    end
    if (g >= 0 && !credit_return) m_cred = m_cred - 1;
    else if (g < 0 && credit_return) begin
      if (m_cred == DEPTH) m_err = 1;
      else m_cred = m_cred + 1;
    end
  endfunction

  task automatic check_outputs(input string tag);
    int g;
    g = model_pick();
    chk({tag, ".grant"}, 32'(grant), (g >= 0) ? 32'(5'b00001 << g) : 32'd0);
    chk({tag, ".sel"}, 32'(xbar_sel), (g >= 0) ? 32'(g) : 32'd0);
    chk({tag, ".valid"}, 32'(xbar_valid), (g >= 0) ? 32'd1 : 32'd0);
    chk({tag, ".credits"}, 32'(credit_count), 32'(m_cred));
    chk({tag, ".busy"}, 32'(busy), 32'(m_locked));
    chk({tag, ".err"}, 32'(credit_err), 32'(m_err));
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance model at the edge.
  task automatic step(input string tag, input logic [4:0] v, input logic [14:0] a,
                      input logic [4:0] t, input logic r);
    int g;
    req_valid = v; nexthop_addr = a; flit_tail = t; credit_return = r;
    @(negedge clk);
    check_outputs(tag);
    g = model_pick();
    $display("cycle %s v=%b t=%b ret=%b grant=%b sel=%0d cred=%0d busy=%b",
             tag, v, t, r, grant, xbar_sel, credit_count, busy);
    @(posedge clk);
    model_clock(g);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_grant"}, 32'(grant), 32'd0);
    chk({tag, ".rst_busy"}, 32'(busy), 32'd0);
    chk({tag, ".rst_cred"}, 32'(credit_count), 32'(DEPTH));
    chk({tag, ".rst_sel"}, 32'(xbar_sel), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // address words: every input pointing at port 2, or N pointing at x
  localparam logic [14:0] ALL2 = {3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

  initial begin
    logic [14:0] a;
    logic [4:0] v;
    logic [4:0] t;
    req_valid = '0; nexthop_addr = '0; flit_tail = '0; credit_return = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");
    step("idle", 5'b00000, ALL2, 5'b00000, 1'b0);

    // single-flit packet from N
    step("single", 5'b00001, ALL2, 5'b00001, 1'b0);
    chk("single.cred3", 32'(credit_count), 32'd3);
    chk("single.busy0", 32'(busy), 32'd0);
    // ptr now 1: S (index 1) beats N when both request
    step("ptr1", 5'b00011, ALL2, 5'b00011, 1'b1);

    // round-robin: N and E alternate with credits refilled
    do_reset("rr");
    for (int i = 0; i < 6; i++) step("rr", 5'b01001, ALL2, 5'b01001, 1'b1);

    // wormhole: S sends 3 flits while L keeps requesting
    do_reset("worm");
    step("worm.head", 5'b10010, ALL2, 5'b10000, 1'b0);
    chk("worm.busy", 32'(busy), 32'd1);
    step("worm.body", 5'b10010, {3'd2, 3'd2, 3'd2, 3'd7, 3'd2}, 5'b10000, 1'b0);
    step("worm.tail", 5'b10010, {3'd2, 3'd2, 3'd2, 3'd7, 3'd2}, 5'b10010, 1'b1);
    step("worm.L", 5'b10000, ALL2, 5'b10000, 1'b1);
    chk("worm.idle", 32'(busy), 32'd0);

    // credit exhaustion and simultaneous grant/return
    do_reset("cred");
    for (int i = 0; i < 6; i++) step("cred.drain", 5'b00001, ALL2, 5'b00000, 1'b0);
    chk("cred.zero", 32'(credit_count), 32'd0);
    step("cred.ret", 5'b00001, ALL2, 5'b00000, 1'b1);
    step("cred.one", 5'b00001, ALL2, 5'b00000, 1'b0);
    step("cred.ret2", 5'b00001, ALL2, 5'b00000, 1'b1);
    step("cred.both", 5'b00001, ALL2, 5'b00001, 1'b1);
    chk("cred.held", 32'(credit_count), 32'd1);
    for (int i = 0; i < 4; i++) step("cred.fill", 5'b00000, ALL2, 5'b00000, 1'b1);
    chk("cred.err", 32'(credit_err), 32'd1);
    step("cred.sticky", 5'b00000, ALL2, 5'b00000, 1'b0);

    // masking: self requests and out-of-range addresses never win
    do_reset("mask");
    step("mask.self", 5'b00100, ALL2, 5'b00100, 1'b0);
    step("mask.a5", 5'b00001, {12'd0, 3'd5}, 5'b00001, 1'b0);
    step("mask.a6", 5'b00001, {12'd0, 3'd6}, 5'b00001, 1'b0);
    step("mask.a7", 5'b00001, {12'd0, 3'd7}, 5'b00001, 1'b0);
    step("mask.a3", 5'b01000, {3'd2, 3'd3, 9'd0}, 5'b01000, 1'b0);

    // reset in the middle of a packet
    step("mid.head", 5'b00001, ALL2, 5'b00000, 1'b0);
    step("mid.body", 5'b00001, ALL2, 5'b00000, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.cred", 32'(credit_count), 32'(DEPTH));
    chk("mid.grant", 32'(grant), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("mid.after", 5'b00001, ALL2, 5'b00001, 1'b0);

    // random traffic
    do_reset("rand");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        a[3*i +: 3] = ($urandom_range(0, 9) < 6) ? 3'd2 : 3'($urandom_range(0, 7));
      end
      v = 5'($urandom);
      t = 5'($urandom);
      step("rand", v, a, t, ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
